pcpi_div_radix: RTL and testbench



---
 rtl/pcpi_div_radix.sv | 152 +++++++++++++++
 tb/tb_pcpi_div_radix.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_div_radix.sv
// rtl/pcpi_div_radix.sv - PCPI co-processor for RV32M DIV/DIVU/REM/REMU, radix-2^BITS_PER_CYCLE restoring divider
//
// Parameters: XLEN (operand width, divisible by BITS_PER_CYCLE), BITS_PER_CYCLE (1, 2 or 4).
// Optional feature macro: DIV_EARLY_OUT_EN (divide-by-zero / |rs1|<|rs2| finish after the first RUN cycle).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   pcpi_valid, pcpi_insn   instruction offered by the core (valid held until ready)
//   pcpi_rs1, pcpi_rs2      dividend, divisor
//   pcpi_wr, pcpi_ready     one-cycle completion pulse, result writes rd
//   pcpi_rd                 result, stable from one ready pulse to the next
//   pcpi_wait               divide accepted and running
module pcpi_div_radix #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);
    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(STEPS);

    typedef enum logic [1:0] {IDLE, RUN, FIN, HOLD} state_t;
    state_t state, state_next;

    logic [XLEN-1:0] quo;     // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic [CW-1:0]   count;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;

    logic is_div;
    logic insn_uns;
    logic unused_insn;
    assign is_div   = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) && pcpi_insn[14];
    assign insn_uns = pcpi_insn[12];
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    // BITS_PER_CYCLE chained restoring steps. A zero divisor naturally yields
    // an all-ones quotient and leaves the dividend as the remainder.
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    always_comb begin
        trial    = '0;
        rem_step = rem;
        quo_step = quo;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial    = {rem_step, quo_step[XLEN-1]};
            quo_step = {quo_step[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs}) begin
                trial       = trial - {1'b0, dvs};
                quo_step[0] = 1'b1;
            end
            rem_step = trial[XLEN-1:0];
        end
    end

`ifdef DIV_EARLY_OUT_EN
    // Only meaningful while count==COUNT_INIT, when quo still holds |rs1|.
    logic early_hit;
    assign early_hit = (dvs == '0) || (quo < dvs);
`endif

    logic [XLEN-1:0] result;
    always_comb begin
        result = '0;
        if (is_rem)
            result = neg_r ? ({XLEN{1'b0}} - rem) : rem;
        else
            result = neg_q ? ({XLEN{1'b0}} - quo) : quo;
    end

    always_comb begin
        state_next = state;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        case (state)
            IDLE: if (pcpi_valid && is_div) state_next = RUN;
            RUN: begin
                pcpi_wait = 1'b1;
                if (!pcpi_valid)
                    state_next = IDLE;
                else if (count == '0)
                    state_next = FIN;
            end
            FIN: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = 1'b1;
                state_next = HOLD;
            end
            // The core still holds valid here; ignoring it prevents a re-issue.
            HOLD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pcpi_rd <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            count   <= '0;
            is_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (pcpi_valid && is_div) begin
                    is_rem <= pcpi_insn[13];
                    quo    <= (!insn_uns && pcpi_rs1[XLEN-1]) ? ({XLEN{1'b0}} - pcpi_rs1) : pcpi_rs1;
                    dvs    <= (!insn_uns && pcpi_rs2[XLEN-1]) ? ({XLEN{1'b0}} - pcpi_rs2) : pcpi_rs2;
                    rem    <= '0;
                    count  <= COUNT_INIT;
                    neg_q  <= !insn_uns && (pcpi_rs1[XLEN-1] ^ pcpi_rs2[XLEN-1]) && (pcpi_rs2 != '0);
                    neg_r  <= !insn_uns && pcpi_rs1[XLEN-1];
                end
                RUN: if (pcpi_valid) begin
                    if (count == '0)
                        pcpi_rd <= result;
`ifdef DIV_EARLY_OUT_EN
                    else if ((count == COUNT_INIT) && early_hit) begin
                        rem   <= quo;
                        quo   <= (dvs == '0) ? '1 : '0;
                        count <= '0;
                    end
`endif
                    else begin
                        rem   <= rem_step;
                        quo   <= quo_step;
                        count <= count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpi_div_radix.sv
// tb/tb_pcpi_div_radix.sv - randomized and directed self-checking bench for pcpi_div_radix
module tb_pcpi_div_radix;
    parameter int BPC   = 1;
    localparam int XLEN  = 32;
    localparam int STEPS = XLEN / BPC;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rd = '0;

    pcpi_div_radix #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // RV32M semantics from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (f3[0]) return f3[1] ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
        return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (!f3[0] && a[31]) ? -a : a;
        mb = (!f3[0] && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
        if (b == 0 || ma < mb) return 2;
`endif
        return (ma == mb) ? STEPS + 1 : STEPS + 1;
    endfunction

    task automatic do_div(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int exp_lat;
        int lat;
        logic wait_ok;
        exp     = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(f3);
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        lat        = -1;
        wait_ok    = 1'b1;
        for (int e = 0; e < 200 && lat < 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (pcpi_ready) lat = e;
            else if (!pcpi_wait) wait_ok = 1'b0;
        end
        if (lat < 0) begin
            check({tag, "_timeout"}, 64'(pcpi_ready), 64'd1);
            pcpi_valid = 1'b0;
            return;
        end
        check({tag, "_rd"}, 64'(pcpi_rd), 64'(exp));
        check({tag, "_wr"}, 64'(pcpi_wr), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_wait"}, 64'(wait_ok), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse"}, 64'({pcpi_ready, pcpi_wr, pcpi_wait}), 64'd0);
        pcpi_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_noreissue"}, 64'({pcpi_ready, pcpi_wait, pcpi_rd}), 64'({2'b00, exp}));
        last_rd = exp;
    endtask

    initial begin
        int bad;
        int rst_edge;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        reset      = 1'b1;
        pcpi_valid = 1'b0;
        pcpi_insn  = '0;
        pcpi_rs1   = '0;
        pcpi_rs2   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'({pcpi_wr, pcpi_ready, pcpi_wait, pcpi_rd}), 64'd0);
        reset = 1'b0;

        do_div("div_20_3",    3'b100, 32'd20, 32'd3);
        do_div("div_m20_3",   3'b100, -32'd20, 32'd3);
        do_div("div_20_m3",   3'b100, 32'd20, -32'd3);
        do_div("div_m20_m3",  3'b100, -32'd20, -32'd3);
        do_div("rem_20_3",    3'b110, 32'd20, 32'd3);
        do_div("rem_m20_3",   3'b110, -32'd20, 32'd3);
        do_div("rem_20_m3",   3'b110, 32'd20, -32'd3);
        do_div("rem_m20_m3",  3'b110, -32'd20, -32'd3);
        do_div("div_min_m1",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("rem_min_m1",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("divu_max_2",  3'b101, 32'hFFFF_FFFF, 32'd2);
        do_div("remu_max_2",  3'b111, 32'hFFFF_FFFF, 32'd2);
        do_div("div_20_0",    3'b100, 32'd20, 32'd0);
        do_div("divu_20_0",   3'b101, 32'd20, 32'd0);
        do_div("rem_20_0",    3'b110, 32'd20, 32'd0);
        do_div("remu_20_0",   3'b111, 32'd20, 32'd0);
        do_div("rem_m20_0",   3'b110, -32'd20, 32'd0);
        do_div("divu_1000_7", 3'b101, 32'd1000, 32'd7);

        // Non-divide instruction held for 50 cycles must be ignored.
        bad = 0;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(3'b000);
        pcpi_rs1   = 32'd20;
        pcpi_rs2   = 32'd3;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (pcpi_wait || pcpi_ready || pcpi_wr) bad++;
        end
        check("mul_ignored", 64'(bad), 64'd0);
        pcpi_valid = 1'b0;

        // Abort mid-RUN: no ready, rd unchanged.
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(3'b101);
        pcpi_rs1   = 32'd123456;
        pcpi_rs2   = 32'd7;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_running", 64'(pcpi_wait), 64'd1);
        pcpi_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (pcpi_ready || pcpi_wait) bad++;
        end
        check("abort_quiet", 64'(bad), 64'd0);
        check("abort_rd", 64'(pcpi_rd), 64'(last_rd));

        // Reset in the middle of a divide.
        rst_edge = (STEPS / 2 < 10) ? STEPS / 2 : 10;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(3'b101);
        pcpi_rs1   = 32'd1000;
        pcpi_rs2   = 32'd7;
        for (int e = 0; e < rst_edge; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun_reset", 64'({pcpi_wr, pcpi_ready, pcpi_wait, pcpi_rd}), 64'd0);
        reset      = 1'b0;
        pcpi_valid = 1'b0;
        do_div("after_reset", 3'b100, 32'd20, 32'd3);

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
                3: b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_div("rand", f3, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
